// File: rtl/vga_grid_capture_pkg.sv
// Shared types and constants for vga_grid_capture: lock states, cell codes,
// reference colours and the 4x4 grid geometry in pixel-clock coordinates.
package vga_cap_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    typedef logic [1:0] cell_code_t;

    localparam cell_code_t CELL_EMPTY = 2'b00;
    localparam cell_code_t CELL_P0    = 2'b01;
    localparam cell_code_t CELL_P1    = 2'b10;
    localparam cell_code_t CELL_INV   = 2'b11;

    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] BLUE   = 24'h0000FF;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] PURPLE = 24'hCC99FF;

    localparam int GRID_DIM   = 4;
    localparam int NUM_CELLS  = GRID_DIM * GRID_DIM;
    localparam int GRID_X0    = 320;
    localparam int GRID_Y0    = 130;
    localparam int GRID_PITCH = 75;
    localparam int GRID_X_OFF = 36;  // +1 over cell centre: source registers its pixel
    localparam int GRID_Y_OFF = 35;

    localparam int              XY_W   = 10;
    localparam logic [XY_W-1:0] XY_MAX = 10'd1023;

    function automatic cell_code_t classify(input logic [23:0] rgb);
        case (rgb)
            WHITE:   return CELL_EMPTY;
            GREEN:   return CELL_P0;
            PURPLE:  return CELL_P1;
            default: return CELL_INV;
        endcase
    endfunction

endpackage

// File: rtl/vga_grid_capture_if.sv
// Incoming VGA video bundle: syncs plus 8-bit RGB, all on the pixel clock.
interface vga_grid_capture_if;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    modport master (output hsync, vsync, red, green, blue);
    modport slave  (input  hsync, vsync, red, green, blue);
endinterface

// File: rtl/vga_sync_lock.sv
// Sync edge detection, x/y raster counters and the timing-lock FSM.
module vga_sync_lock
    import vga_cap_pkg::*;
#(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 526,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                clk,
    input  logic                rst,
    vga_grid_capture_if.slave   vid,
    output logic [XY_W-1:0]     x,
    output logic [XY_W-1:0]     y,
    output logic                hs_edge,
    output logic                vs_edge,
    output logic                locked
);

    localparam int CW = $clog2(LOCK_FRAMES + 1);

    logic [1:0]    hs_q, vs_q;
    lock_state_t   state, state_n;
    logic [CW-1:0] good_cnt, good_cnt_n;
    logic          lines_ok, line_bad, frame_good;

    assign hs_edge = hs_q[0] & ~hs_q[1];
    assign vs_edge = vs_q[0] & ~vs_q[1];
    // a coincident vsync edge makes this a frame boundary, not a line check
    assign line_bad   = hs_edge & ~vs_edge & (x != XY_W'(H_TOTAL - 1));
    assign frame_good = lines_ok & (y == XY_W'(V_TOTAL - 1));
    assign locked     = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= '0;
            vs_q <= '0;
            x    <= '0;
            y    <= '0;
        end else begin
            hs_q <= {hs_q[0], vid.hsync};
            vs_q <= {vs_q[0], vid.vsync};
            if (hs_edge)            x <= '0;
            else if (x != XY_MAX)   x <= x + 1'b1;
            if (vs_edge)                      y <= '0;
            else if (hs_edge && y != XY_MAX)  y <= y + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
            lines_ok <= 1'b0;
        end else begin
            state    <= state_n;
            good_cnt <= good_cnt_n;
            if (vs_edge)        lines_ok <= 1'b1;
            else if (line_bad)  lines_ok <= 1'b0;
        end
    end

    always_comb begin
        state_n    = state;
        good_cnt_n = good_cnt;
        case (state)
            SEARCH: if (vs_edge) begin
                state_n    = MEASURE;
                good_cnt_n = '0;
            end
            MEASURE: if (vs_edge) begin
                if (!frame_good) begin
                    good_cnt_n = '0;
                end else if (good_cnt == CW'(LOCK_FRAMES - 1)) begin
                    state_n    = LOCKED;
                    good_cnt_n = '0;
                end else begin
                    good_cnt_n = good_cnt + 1'b1;
                end
            end
            LOCKED: if (line_bad || (vs_edge && !frame_good)) state_n = SEARCH;
            default: state_n = SEARCH;
        endcase
    end

endmodule

// File: rtl/vga_grid_capture.sv
// Samples a 4x4 board from a VGA stream once timing is locked and publishes
// 2-bit cell codes per frame. Define VGA_CAP_STATS_EN for frame/error counters.
module vga_grid_capture
    import vga_cap_pkg::*;
#(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 526,
    parameter int LOCK_FRAMES = 2,
    parameter int X0          = GRID_X0,
    parameter int Y0          = GRID_Y0,
    parameter int PITCH       = GRID_PITCH,
    parameter int X_OFF       = GRID_X_OFF,
    parameter int Y_OFF       = GRID_Y_OFF
) (
    input  logic        VGA_CLK_IN,
    input  logic        RST,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    output logic [31:0] o_cells,
    output logic        o_frame_valid,
    output logic        o_locked
`ifdef VGA_CAP_STATS_EN
    ,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_err_cnt
`endif
);

    vga_grid_capture_if vid ();
    assign vid.hsync = i_hsync;
    assign vid.vsync = i_vsync;
    assign vid.red   = i_red;
    assign vid.green = i_green;
    assign vid.blue  = i_blue;

    logic [XY_W-1:0]     x, y;
    logic                hs_edge, vs_edge, locked;
    logic [GRID_DIM-1:0] col_hit, row_hit;
    logic [31:0]         shadow;
    cell_code_t          code;

    vga_sync_lock #(
        .H_TOTAL     (H_TOTAL),
        .V_TOTAL     (V_TOTAL),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_lock (
        .clk     (VGA_CLK_IN),
        .rst     (RST),
        .vid     (vid),
        .x       (x),
        .y       (y),
        .hs_edge (hs_edge),
        .vs_edge (vs_edge),
        .locked  (locked)
    );

    for (genvar i = 0; i < GRID_DIM; i++) begin : g_hit
        assign col_hit[i] = (x == XY_W'(X0 + PITCH * i + X_OFF));
        assign row_hit[i] = (y == XY_W'(Y0 + PITCH * i + Y_OFF));
    end

    assign code     = classify({vid.red, vid.green, vid.blue});
    assign o_locked = locked;

    // clearing to invalid after the copy flags cells the raster never reached
    always_ff @(posedge VGA_CLK_IN or posedge RST) begin
        if (RST) begin
            shadow <= '0;
        end else if (vs_edge) begin
            shadow <= '1;
        end else begin
            for (int r = 0; r < GRID_DIM; r++)
                for (int c = 0; c < GRID_DIM; c++)
                    if (row_hit[r] && col_hit[c]) shadow[2*(GRID_DIM*r+c) +: 2] <= code;
        end
    end

    always_ff @(posedge VGA_CLK_IN or posedge RST) begin
        if (RST) begin
            o_cells       <= '0;
            o_frame_valid <= 1'b0;
        end else begin
            o_frame_valid <= vs_edge & locked;
            if (vs_edge && locked) o_cells <= shadow;
        end
    end

`ifdef VGA_CAP_STATS_EN
    logic locked_q;

    always_ff @(posedge VGA_CLK_IN or posedge RST) begin
        if (RST) begin
            locked_q    <= 1'b0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            locked_q <= locked;
            if (vs_edge && locked) o_frame_cnt <= o_frame_cnt + 1'b1;
            if (locked_q && !locked && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_grid_capture.sv
// Scoreboard bench for vga_grid_capture on a shrunken 40x30 raster with a
// scaled grid; frame expectations are queued at stimulus time and checked on o_frame_valid.
`timescale 1ns/1ps
module tb_vga_grid_capture;
    import vga_cap_pkg::*;

    localparam int H  = 40;
    localparam int V  = 30;
    localparam int P  = 6;
    localparam int X0 = 4;
    localparam int Y0 = 3;
    localparam int XO = 4;
    localparam int YO = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_grid_capture_if vid ();

    logic [31:0] cells;
    logic        fv, lk;
`ifdef VGA_CAP_STATS_EN
    logic [15:0] fcnt;
    logic [7:0]  ecnt;
`endif

    vga_grid_capture #(
        .H_TOTAL (H), .V_TOTAL (V), .LOCK_FRAMES (2),
        .X0 (X0), .Y0 (Y0), .PITCH (P), .X_OFF (XO), .Y_OFF (YO)
    ) u_dut (
        .VGA_CLK_IN    (clk),
        .RST           (rst),
        .i_hsync       (vid.hsync),
        .i_vsync       (vid.vsync),
        .i_red         (vid.red),
        .i_green       (vid.green),
        .i_blue        (vid.blue),
        .o_cells       (cells),
        .o_frame_valid (fv),
        .o_locked      (lk)
`ifdef VGA_CAP_STATS_EN
        ,
        .o_frame_cnt   (fcnt),
        .o_err_cnt     (ecnt)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [23:0] paint [16];
    bit          red_dot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic set_paint(input logic [23:0] bg);
        for (int i = 0; i < 16; i++) paint[i] = bg;
        red_dot = 1'b0;
    endtask

    // DUT x lags the driven column by 2 (sync register + edge-detect stage)
    function automatic logic [23:0] pix(input int v, input int h);
        int x;
        x = h - 2;
        if (red_dot && v == Y0 + YO && x == X0 + XO) return 24'hFF0000;
        if (x >= X0 && x < X0 + 4*P && v >= Y0 && v < Y0 + 4*P)
            return paint[((v - Y0) / P) * 4 + (x - X0) / P];
        return 24'h000000;
    endfunction

    task automatic reset_mid_frame();
        @(negedge clk);
        chk("locked_before_rst", 32'(lk), 32'd1);
`ifdef VGA_CAP_STATS_EN
        chk("frame_cnt_before_rst", 32'(fcnt), 32'd4);
        chk("err_cnt_before_rst", 32'(ecnt), 32'd1);
`endif
        rst = 1'b1;
        #1;
        chk("rst_mid_cells", cells, 32'h0);
        chk("rst_mid_valid", 32'(fv), 32'd0);
        chk("rst_mid_locked", 32'(lk), 32'd0);
`ifdef VGA_CAP_STATS_EN
        chk("rst_mid_frame_cnt", 32'(fcnt), 32'd0);
        chk("rst_mid_err_cnt", 32'(ecnt), 32'd0);
`endif
        vid.hsync = 1'b0;
        vid.vsync = 1'b0;
        {vid.red, vid.green, vid.blue} = 24'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_frame(input bit push, input logic [31:0] exp_cells, input int short_line,
                               input int rst_line, input int lock_end, input bit chk_xy);
        if (push) exp_q.push_back(exp_cells);
        for (int v = 0; v < V; v++) begin
            if (v == rst_line) begin
                reset_mid_frame();
                return;
            end
            for (int h = 0; h < ((v == short_line) ? H - 1 : H); h++) begin
                @(negedge clk);
                if (chk_xy && v == 0 && h == 2) begin
                    chk("x_after_both_edges", 32'(u_dut.u_lock.x), 32'd0);
                    chk("y_after_both_edges", 32'(u_dut.u_lock.y), 32'd0);
                end
                vid.hsync = (h < 4);
                vid.vsync = (v < 2);
                {vid.red, vid.green, vid.blue} = pix(v, h);
            end
        end
        if (lock_end >= 0) chk("locked_at_frame_end", 32'(lk), 32'(lock_end));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (fv) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_valid: o_cells=%h, want no pulse", cells);
                end else begin
                    chk("frame_cells", cells, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        vid.hsync = 1'b0;
        vid.vsync = 1'b0;
        {vid.red, vid.green, vid.blue} = 24'h0;
        set_paint(WHITE);
        repeat (3) @(negedge clk);
        chk("reset_cells", cells, 32'h0);
        chk("reset_valid", 32'(fv), 32'd0);
        chk("reset_locked", 32'(lk), 32'd0);
        rst = 1'b0;

        drive_frame(1'b0, 32'h0, -1, -1, -1, 1'b0);           // SEARCH -> MEASURE
        drive_frame(1'b0, 32'h0, -1, -1, 0, 1'b0);            // good frame 1
        drive_frame(1'b1, 32'h0, -1, -1, 1, 1'b0);            // locked, empty board
        paint[5]  = GREEN;
        paint[10] = PURPLE;
        drive_frame(1'b1, 32'h0020_0400, -1, -1, 1, 1'b0);
        set_paint(WHITE);
        red_dot = 1'b1;
        drive_frame(1'b1, 32'h0000_0003, -1, -1, 1, 1'b0);
        red_dot = 1'b0;
        drive_frame(1'b0, 32'h0, 10, -1, 0, 1'b0);            // short line drops lock
`ifdef VGA_CAP_STATS_EN
        chk("err_cnt_after_short_line", 32'(ecnt), 32'd1);
`endif
        drive_frame(1'b0, 32'h0, -1, -1, 0, 1'b0);
        drive_frame(1'b0, 32'h0, -1, -1, 0, 1'b0);
        paint[0]  = PURPLE;
        paint[15] = GREEN;
        drive_frame(1'b1, 32'h4000_0002, -1, -1, 1, 1'b1);    // relocked
        set_paint(WHITE);
        drive_frame(1'b0, 32'h0, -1, 10, -1, 1'b0);           // reset mid-frame
        drive_frame(1'b0, 32'h0, -1, -1, 0, 1'b0);
        drive_frame(1'b0, 32'h0, -1, -1, 0, 1'b0);
        drive_frame(1'b0, 32'h0, -1, -1, 1, 1'b0);
        repeat (5) @(negedge clk);
        chk("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
